// File: rtl/alu_seq.sv
// Sequential ALU: one operation per valid/ready request, with registered result and flags.
// MUL runs as a WIDTH-cycle shift-add loop. All other ops finish in one cycle.
//
// state | meaning
// IDLE  | ready for a request
// MUL   | shift-add iterations in progress
// DONE  | result/flags just updated, valid_o high
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] r_o,
    output logic             fz_o,
    output logic             fc_o,
    output logic             fn_o,
    output logic             fv_o,
    output logic             valid_o
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   alu_r;
    logic               alu_c;
    logic               alu_v;
    logic [2*WIDTH-1:0] acc_nxt;

    // Single-cycle ops are evaluated straight from the request inputs and
    // captured at the accept edge, which is the same as latching the operands.
    always_comb begin
        sum_ext = '0;
        alu_r   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_i)
            OP_ADD: begin
                sum_ext = {1'b0, x_i} + {1'b0, y_i};
                alu_r   = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (x_i[WIDTH-1] == y_i[WIDTH-1]) && (alu_r[WIDTH-1] != x_i[WIDTH-1]);
            end
            OP_SUB: begin
                sum_ext = {1'b0, x_i} - {1'b0, y_i};
                alu_r   = sum_ext[WIDTH-1:0];
                alu_c   = (x_i < y_i);
                alu_v   = (x_i[WIDTH-1] != y_i[WIDTH-1]) && (alu_r[WIDTH-1] != x_i[WIDTH-1]);
            end
            OP_AND: alu_r = x_i & y_i;
            OP_OR:  alu_r = x_i | y_i;
            OP_XOR: alu_r = x_i ^ y_i;
            OP_SHR: begin
                alu_r = x_i >> 1;
                alu_c = x_i[0];
            end
            OP_SHL: begin
                alu_r = x_i << 1;
                alu_c = x_i[WIDTH-1];
            end
            default: begin
                alu_r = '0;
            end
        endcase
    end

    assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= S_IDLE;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            r_o     <= '0;
            fz_o    <= 1'b0;
            fc_o    <= 1'b0;
            fn_o    <= 1'b0;
            fv_o    <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid_i && ready_o) begin
                        ready_o <= 1'b0;
                        if (op_i == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, x_i};
                            mplier <= y_i;
                            cnt    <= CW'(WIDTH);
                            state  <= S_MUL;
                        end else begin
                            r_o     <= alu_r;
                            fz_o    <= (alu_r == '0);
                            fc_o    <= alu_c;
                            fn_o    <= alu_r[WIDTH-1];
                            fv_o    <= alu_v;
                            valid_o <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    // Terminal count: this edge performs the last iteration.
                    if (cnt == CW'(1)) begin
                        r_o     <= acc_nxt[WIDTH-1:0];
                        fz_o    <= (acc_nxt[WIDTH-1:0] == '0);
                        fc_o    <= |acc_nxt[2*WIDTH-1:WIDTH];
                        fn_o    <= acc_nxt[WIDTH-1];
                        fv_o    <= 1'b0;
                        valid_o <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    ready_o <= 1'b1;
                    state   <= S_IDLE;
                end
                default: begin
                    ready_o <= 1'b1;
                    state   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): directed vectors, a monitor compares
// every valid_o pulse against the queued expectation.
module tb_alu_seq;
    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [2:0] op_i = 3'd0;
    logic [7:0] x_i = 8'd0;
    logic [7:0] y_i = 8'd0;
    logic [7:0] r_o;
    logic       fz_o, fc_o, fn_o, fv_o, valid_o;

    typedef struct packed {
        logic [7:0] r;
        logic       z;
        logic       c;
        logic       n;
        logic       v;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   n_res = 0;
    logic [7:0] prev_r = 8'd0;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
    localparam logic [2:0] XOR_ = 3'd4, SHR = 3'd5, SHL = 3'd6, MUL = 3'd7;

    alu_seq #(.WIDTH(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .x_i(x_i), .y_i(y_i), .r_o(r_o),
        .fz_o(fz_o), .fc_o(fc_o), .fn_o(fn_o), .fv_o(fv_o), .valid_o(valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && valid_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("res%0d_r", n_res), int'(r_o), int'(e.r));
                chk($sformatf("res%0d_z", n_res), int'(fz_o), int'(e.z));
                chk($sformatf("res%0d_c", n_res), int'(fc_o), int'(e.c));
                chk($sformatf("res%0d_n", n_res), int'(fn_o), int'(e.n));
                chk($sformatf("res%0d_v", n_res), int'(fv_o), int'(e.v));
                n_res++;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                         input exp_t e, input bit poke);
        int lat;
        bit rdy_ok;
        bit hold_ok;
        lat = 0;
        while (!ready_o && lat < 50) begin
            @(posedge clk_i); #1;
            lat++;
        end
        valid_i = 1'b1; op_i = op; x_i = x; y_i = y;
        sb.push_back(e);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        x_i = 8'($urandom); y_i = 8'($urandom);
        lat = 1; rdy_ok = 1'b1; hold_ok = 1'b1;
        while (!valid_o && lat < 40) begin
            if (ready_o) rdy_ok = 1'b0;
            if (r_o !== prev_r) hold_ok = 1'b0;
            if (poke && lat == 3) begin
                valid_i = 1'b1; op_i = ADD; x_i = 8'd1; y_i = 8'd1;
            end else begin
                valid_i = 1'b0;
            end
            @(posedge clk_i); #1;
            lat++;
        end
        valid_i = 1'b0;
        chk("latency", lat, (op == MUL) ? 9 : 1);
        chk("ready_in_done", int'(ready_o), 0);
        if (op == MUL) begin
            chk("ready_low_window", int'(rdy_ok), 1);
            chk("r_hold_during_mul", int'(hold_ok), 1);
        end
        prev_r = e.r;
        @(posedge clk_i); #1;
        chk("ready_back", int'(ready_o), 1);
        chk("valid_single", int'(valid_o), 0);
    endtask

    initial begin
        // reset held with toggling inputs
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'($urandom); op_i = 3'($urandom);
            x_i = 8'($urandom); y_i = 8'($urandom);
            @(posedge clk_i); #1;
        end
        chk("rst_r", int'(r_o), 0);
        chk("rst_flags", int'({fz_o, fc_o, fn_o, fv_o}), 0);
        chk("rst_ready", int'(ready_o), 1);
        chk("rst_valid", int'(valid_o), 0);
        valid_i = 1'b0;
        rst_ni = 1'b1;

        //             r      z     c     n     v
        issue(ADD, 8'd1,   8'd1,   {8'd2,   1'b0, 1'b0, 1'b0, 1'b0}, 1'b0);
        issue(ADD, 8'd200, 8'd100, {8'd44,  1'b0, 1'b1, 1'b0, 1'b0}, 1'b0);
        issue(ADD, 8'd127, 8'd1,   {8'd128, 1'b0, 1'b0, 1'b1, 1'b1}, 1'b0);
        issue(ADD, 8'd255, 8'd1,   {8'd0,   1'b1, 1'b1, 1'b0, 1'b0}, 1'b0);
        issue(SUB, 8'd5,   8'd2,   {8'd3,   1'b0, 1'b0, 1'b0, 1'b0}, 1'b0);
        issue(SUB, 8'd3,   8'd3,   {8'd0,   1'b1, 1'b0, 1'b0, 1'b0}, 1'b0);
        issue(SUB, 8'd1,   8'd4,   {8'd253, 1'b0, 1'b1, 1'b1, 1'b0}, 1'b0);
        issue(SUB, 8'd128, 8'd1,   {8'd127, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b0);
        issue(AND_, 8'hF0, 8'h3C,  {8'h30,  1'b0, 1'b0, 1'b0, 1'b0}, 1'b0);
        issue(XOR_, 8'hAA, 8'hAA,  {8'h00,  1'b1, 1'b0, 1'b0, 1'b0}, 1'b0);
        issue(SHL, 8'h81,  8'h00,  {8'h02,  1'b0, 1'b1, 1'b0, 1'b0}, 1'b0);
        issue(SHR, 8'h01,  8'h00,  {8'h00,  1'b1, 1'b1, 1'b0, 1'b0}, 1'b0);
        issue(OR_, 8'h0F,  8'h80,  {8'h8F,  1'b0, 1'b0, 1'b1, 1'b0}, 1'b0);
        issue(MUL, 8'd12,  8'd11,  {8'd132, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b1);
        issue(MUL, 8'd16,  8'd16,  {8'd0,   1'b1, 1'b1, 1'b0, 1'b0}, 1'b0);
        issue(MUL, 8'd255, 8'd255, {8'd1,   1'b0, 1'b1, 1'b0, 1'b0}, 1'b0);

        // reset in the middle of a multiply
        valid_i = 1'b1; op_i = MUL; x_i = 8'd200; y_i = 8'd3;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        chk("midrst_r", int'(r_o), 0);
        chk("midrst_flags", int'({fz_o, fc_o, fn_o, fv_o}), 0);
        chk("midrst_ready", int'(ready_o), 1);
        chk("midrst_valid", int'(valid_o), 0);
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        prev_r = 8'd0;
        issue(ADD, 8'd2, 8'd3, {8'd5, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0);

        repeat (12) @(posedge clk_i);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, sequential successor to the 8-bit combinational `alu`. It executes one operation per request under a valid/ready handshake, registers the result and a four-flag status word, and adds an iterative shift-add multiplier that runs over multiple cycles. It sits between the control unit and the accumulator/register file: the control unit issues an operation and waits for `valid_o` before latching the result and the flags.

## Interface
- `WIDTH`, default 8: datapath width in bits; must be ≥ 4.
- `clk_i`  in  1  clock; rising edge active.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `valid_i`  in  1  request strobe; an operation is accepted when `valid_i && ready_o`.
- `ready_o`  out  1  high only in IDLE.
- `op_i`  in  3  opcode, sampled at accept:
  - 000 ADD, 001 SUB, 010 AND, 011 OR
  - 100 XOR, 101 SHR, 110 SHL, 111 MUL
- `x_i`  in  WIDTH  operand A, sampled at accept.
- `y_i`  in  WIDTH  operand B, sampled at accept.
- `r_o`  out  WIDTH  registered result.
- `fz_o`  out  1  zero flag.
- `fc_o`  out  1  carry/borrow flag.
- `fn_o`  out  1  negative flag.
- `fv_o`  out  1  signed-overflow flag.
- `valid_o`  out  1  one-cycle pulse; `r_o` and the flags were updated this cycle.

## Operation
- FSM has three states: IDLE, MUL, DONE.
  - IDLE → DONE on accepting a non-MUL op. The result and flags are computed combinationally from the latched operands and registered on this transition.
  - IDLE → MUL on accepting MUL.
  - MUL → DONE after exactly WIDTH iterations.
  - DONE → IDLE unconditionally.
- `valid_i` is ignored outside IDLE. It is not queued.
- `r_o` and the flags update only on entry to DONE and hold their values until the next completion.
- Result rules (all mod 2^WIDTH):
  - ADD: r = x+y.
  - SUB: r = x−y.
  - AND/OR/XOR: bitwise.
  - SHR: r = x>>1, zero fill.
  - SHL: r = x<<1, zero fill.
  - MUL: r = low WIDTH bits of x·y, unsigned.
- Flag rules:
  - Z = (r == 0) for all ops.
  - N = r[WIDTH-1] for all ops.
  - C:
    - ADD: carry out.
    - SUB: borrow, i.e. 1 iff x < y unsigned.
    - SHR: x[0].
    - SHL: x[WIDTH-1].
    - MUL: 1 iff the upper WIDTH bits of the product are nonzero.
    - AND/OR/XOR: 0.
  - V:
    - ADD: x and y have the same sign and r's sign differs.
    - SUB: x and y have different signs and r's sign differs from x.
    - All other ops: 0.
- Multiplier: 2·WIDTH-bit accumulator, shifted multiplicand and multiplier registers, and an iteration counter of `$clog2(WIDTH+1)` bits. Each MUL cycle conditionally adds the multiplicand and shifts once. The operands are latched at accept, so changes on `x_i`/`y_i` during MUL have no effect.
- Reset, asserted asynchronously at any time, including mid-MUL:
  - state goes to IDLE;
  - `r_o`, all flags, the accumulator and the counter go to 0;
  - `valid_o` = 0, `ready_o` = 1.
  - No partial result is ever presented.

## Timing
- Accept at edge n (`valid_i && ready_o` sampled high).
- Non-MUL ops: `valid_o` = 1 and the new `r_o`/flags are visible in cycle n+1. `ready_o` = 0 in cycle n+1 and returns to 1 in n+2.
  - Maximum throughput is one op per 2 cycles.
- MUL: `ready_o` = 0 for cycles n+1 … n+WIDTH+1. `valid_o` pulses in cycle n+WIDTH+1, which is cycle n+9 for WIDTH=8. `ready_o` = 1 again in n+WIDTH+2.
- `valid_o` is never high for more than one consecutive cycle.
- Reset release: the first accept is possible on the first rising edge after `rst_ni` rises.

## Test plan
All scenarios use WIDTH=8.
- **Reset:** hold `rst_ni`=0 with toggling inputs → `r_o`=0, fz/fc/fn/fv=0, `ready_o`=1, `valid_o`=0. Release, then issue ADD 1+1 → r=2, Z=0, C=0, with `valid_o` exactly one cycle after accept.
- **ADD edges:**
  - 200+100 → r=44, C=1, V=0.
  - 127+1 → r=128, N=1, V=1, C=0.
  - 255+1 → r=0, Z=1, C=1.
- **SUB:**
  - 5−2 → r=3, all flags 0.
  - 3−3 → r=0, Z=1, C=0.
  - 1−4 → r=253, C=1, N=1.
  - 128−1 → r=127, V=1.
- **Logic/shift:**
  - AND 0xF0,0x3C → 0x30.
  - XOR 0xAA,0xAA → 0, Z=1.
  - SHL 0x81 → 0x02, C=1.
  - SHR 0x01 → 0x00, Z=1, C=1.
- **MUL:**
  - 12·11 → r=132, C=0, N=1, with `valid_o` at accept+9 and `ready_o` low for 9 cycles. A `valid_i` pulse with ADD during this window is ignored, and `r_o` holds its previous value until completion.
  - 16·16 → r=0, Z=1, C=1.
  - 255·255 → r=1, C=1.
- **Reset mid-MUL:** start 200·3, assert `rst_ni`=0 at accept+4 → immediately `r_o`=0, flags=0, `ready_o`=1, and no `valid_o`. After release, ADD 2+3 → r=5 with normal latency.
